// File: rtl/rv_fetch_pc_pkg.sv
// ============================================================================
// rv_fetch_pc_pkg
// ----------------------------------------------------------------------------
// Shared types and constants for the fetch/PC stage.
//   - fetch_state_e : fetch FSM states (FETCH, WAIT, ISSUE, HALT)
//   - pc_ops_t      : one-hot PC opcode produced by the decoder
//   - Pc*           : the individual one-hot opcode values
//   - InstrBytes    : size of one instruction in bytes (sequential PC step)
//   - is_onehot()   : true when exactly one bit of a PC opcode is set
// ============================================================================
package rv_fetch_pc_pkg;

    localparam int InstrBytes = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    typedef logic [4:0] pc_ops_t;

    localparam pc_ops_t PcStop   = 5'b00001;
    localparam pc_ops_t PcIncr   = 5'b00010;
    localparam pc_ops_t PcJAL    = 5'b00100;
    localparam pc_ops_t PcJALR   = 5'b01000;
    localparam pc_ops_t PcBranch = 5'b10000;

    // x & (x-1) clears the lowest set bit; zero afterwards means at most
    // one bit was set, and the non-zero test rules out the empty opcode.
    function automatic logic is_onehot(input pc_ops_t op);
        pc_ops_t op_m1;
        op_m1 = op - pc_ops_t'(1);
        return (op != '0) && ((op & op_m1) == '0);
    endfunction

endpackage : rv_fetch_pc_pkg

// File: rtl/rv_fetch_pc_if.sv
// ============================================================================
// rv_fetch_pc_if
// ----------------------------------------------------------------------------
// Bundles the three channels the fetch stage talks on:
//   imem request  : imem_valid / imem_ready / imem_addr
//   imem response : rsp_valid / rsp_data (one response per accepted request)
//   decode channel: instr_valid / instr_ready / instr / instr_pc, plus the
//                   decoder's PC control returned in the accept cycle
//                   (pc_op, imm, rs1, br_taken)
// Modports:
//   master : the fetch stage (rv_fetch_pc)
//   slave  : the environment (imem + decode)
// ============================================================================
interface rv_fetch_pc_if
    import rv_fetch_pc_pkg::*;
#(
    parameter int XLEN = 32
);
    // imem request
    logic            imem_valid;
    logic            imem_ready;
    logic [XLEN-1:0] imem_addr;
    // imem response
    logic            rsp_valid;
    logic [31:0]     rsp_data;
    // decode channel
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    // decoder PC control, meaningful while instr_valid && instr_ready
    pc_ops_t         pc_op;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic            br_taken;

    modport master (
        output imem_valid, imem_addr,
        input  imem_ready,
        input  rsp_valid, rsp_data,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        input  pc_op, imm, rs1, br_taken
    );

    modport slave (
        input  imem_valid, imem_addr,
        output imem_ready,
        output rsp_valid, rsp_data,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        output pc_op, imm, rs1, br_taken
    );

endinterface : rv_fetch_pc_if

// File: rtl/rv_fetch_pc_pc_next.sv
// ============================================================================
// rv_pc_next
// ----------------------------------------------------------------------------
// Purely combinational next-PC computation and fault classification.
// Ports:
//   pc         in   XLEN  current PC (PC of the instruction being accepted)
//   op         in   5     one-hot PC opcode from decode
//   imm        in   XLEN  sign-extended J/B immediate
//   rs1        in   XLEN  JALR base register value
//   taken      in   1     branch condition result
//   next_pc    out  XLEN  candidate next PC (equals pc for stop / illegal)
//   stop       out  1     opcode is PcStop
//   misaligned out  1     legal, non-stop op whose target has bit 1 set
//   illegal    out  1     opcode is zero or has several bits set
// All arithmetic wraps modulo 2^XLEN.
// ============================================================================
module rv_pc_next
    import rv_fetch_pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  pc_ops_t         op,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            taken,
    output logic [XLEN-1:0] next_pc,
    output logic            stop,
    output logic            misaligned,
    output logic            illegal
);

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] rel_pc;
    logic [XLEN-1:0] jalr_pc;

    assign seq_pc  = pc + XLEN'(InstrBytes);
    assign rel_pc  = pc + imm;
    // JALR clears bit 0 of the sum before the alignment check.
    assign jalr_pc = (rs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};

    always_comb begin
        next_pc = pc;
        stop    = 1'b0;
        illegal = !is_onehot(op);
        case (op)
            PcIncr:   next_pc = seq_pc;
            PcJAL:    next_pc = rel_pc;
            PcJALR:   next_pc = jalr_pc;
            PcBranch: next_pc = taken ? rel_pc : seq_pc;
            PcStop:   stop    = 1'b1;
            default:  next_pc = pc;
        endcase
        // Only bit 1 is checked: bit 0 is already cleared for JALR and
        // J/B immediates are always even.
        misaligned = !illegal && !stop && next_pc[1];
    end

endmodule : rv_pc_next

// File: rtl/rv_fetch_pc.sv
// ============================================================================
// rv_fetch_pc
// ----------------------------------------------------------------------------
// PC register and instruction-fetch stage. Holds the PC, issues one imem
// request at a time, captures the returned word and offers it to decode.
// When decode accepts, the decoder's PC opcode selects the next PC.
// The stage halts (sticky until reset) on PcStop, a misaligned target or an
// opcode that is not one-hot.
// Ports:
//   clk       in   1     clock, rising edge
//   rstn      in   1     asynchronous active-low reset
//   fb        master    imem request/response and decode channels
//   o_halted  out  1     core halted (sticky until reset)
//   o_fault   out  2     sticky: [0] misaligned target, [1] non-one-hot op
// FSM: FETCH -> WAIT -> ISSUE -> FETCH, best case one instruction every
// three cycles; ISSUE may go to HALT, which only reset leaves.
// ============================================================================
module rv_fetch_pc
    import rv_fetch_pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rstn,
    rv_fetch_pc_if.master       fb,
    output logic                o_halted,
    output logic [1:0]          o_fault
);

    fetch_state_e    state_reg,    state_next;
    logic [XLEN-1:0] pc_reg,       pc_next;
    logic [31:0]     instr_reg,    instr_next;
    logic [XLEN-1:0] instr_pc_reg, instr_pc_next;
    logic [1:0]      fault_reg,    fault_next;

    logic [XLEN-1:0] calc_pc;
    logic            calc_stop;
    logic            calc_misaligned;
    logic            calc_illegal;
    logic            req_fire;
    logic            instr_fire;

    // ------------------------------------------------------------------
    // Next-PC datapath. Uses pc_reg, which equals instr_pc_reg while in
    // ISSUE, so the target is relative to the instruction being accepted.
    // ------------------------------------------------------------------
    rv_pc_next #(
        .XLEN (XLEN)
    ) u_pc_next (
        .pc         (pc_reg),
        .op         (fb.pc_op),
        .imm        (fb.imm),
        .rs1        (fb.rs1),
        .taken      (fb.br_taken),
        .next_pc    (calc_pc),
        .stop       (calc_stop),
        .misaligned (calc_misaligned),
        .illegal    (calc_illegal)
    );

    // ------------------------------------------------------------------
    // Outputs. The request valid is qualified with rstn so nothing is
    // requested while reset is held, even though the state already reads
    // FETCH; the first request appears as soon as rstn rises.
    // ------------------------------------------------------------------
    assign fb.imem_valid  = (state_reg == FETCH) && rstn;
    assign fb.imem_addr   = pc_reg;
    assign fb.instr_valid = (state_reg == ISSUE);
    assign fb.instr       = instr_reg;
    assign fb.instr_pc    = instr_pc_reg;
    assign o_halted       = (state_reg == HALT);
    assign o_fault        = fault_reg;

    assign req_fire   = fb.imem_valid && fb.imem_ready;
    assign instr_fire = fb.instr_valid && fb.instr_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
            fault_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
            fault_reg    <= fault_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
        fault_next    = fault_reg;

        case (state_reg)
            FETCH: begin
                if (req_fire) begin
                    state_next = WAIT;
                end
            end

            // Responses are only looked at here; anything arriving in
            // another state (e.g. left over from before a reset) is dropped.
            WAIT: begin
                if (fb.rsp_valid) begin
                    state_next    = ISSUE;
                    instr_next    = fb.rsp_data;
                    instr_pc_next = pc_reg;
                end
            end

            ISSUE: begin
                if (instr_fire) begin
                    if (calc_illegal) begin
                        state_next    = HALT;
                        fault_next[1] = 1'b1;
                    end else if (calc_stop) begin
                        state_next = HALT;
                    end else if (calc_misaligned) begin
                        // PC keeps the faulting instruction's address.
                        state_next    = HALT;
                        fault_next[0] = 1'b1;
                    end else begin
                        state_next = FETCH;
                        pc_next    = calc_pc;
                    end
                end
            end

            HALT: begin
                state_next = HALT;
            end

            default: begin
                state_next = HALT;
            end
        endcase
    end

endmodule : rv_fetch_pc
